// File: rtl/countdown_hms_pkg.sv
// Shared types and constants for the hh:mm:ss countdown timer.
// Count widths match the up-counting time-of-day counter so both can share the display path.
package countdown_hms_pkg;

    localparam int unsigned HH_W = 5;
    localparam int unsigned MM_W = 6;
    localparam int unsigned SS_W = 6;

    localparam logic [HH_W-1:0] MAX_HH = HH_W'(23);
    localparam logic [MM_W-1:0] MAX_MM = MM_W'(59);
    localparam logic [SS_W-1:0] MAX_SS = SS_W'(59);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    typedef struct packed {
        logic [HH_W-1:0] hh;
        logic [MM_W-1:0] mm;
        logic [SS_W-1:0] ss;
    } hms_t;

    // Clamp an arbitrary preset into a legal time value.
    function automatic hms_t sat_hms(input logic [HH_W-1:0] hh,
                                     input logic [MM_W-1:0] mm,
                                     input logic [SS_W-1:0] ss);
        hms_t r;
        r.hh = (hh > MAX_HH) ? MAX_HH : hh;
        r.mm = (mm > MAX_MM) ? MAX_MM : mm;
        r.ss = (ss > MAX_SS) ? MAX_SS : ss;
        return r;
    endfunction

    // One-second decrement with ss -> mm -> hh borrow; never called on 00:00:00.
    function automatic hms_t dec_hms(input hms_t t);
        hms_t r;
        r = t;
        if (t.ss != '0) begin
            r.ss = t.ss - SS_W'(1);
        end else begin
            r.ss = MAX_SS;
            if (t.mm != '0) begin
                r.mm = t.mm - MM_W'(1);
            end else begin
                r.mm = MAX_MM;
                r.hh = t.hh - HH_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_hms_if.sv
// Control and count bus of the countdown timer; master drives requests, slave returns counts.
interface countdown_hms_if;
    import countdown_hms_pkg::*;

    logic            load;
    logic [HH_W-1:0] load_hh;
    logic [MM_W-1:0] load_mm;
    logic [SS_W-1:0] load_ss;
    logic            start;
    logic            pause;
    logic [HH_W-1:0] count_hh;
    logic [MM_W-1:0] count_mm;
    logic [SS_W-1:0] count_ss;
    logic            running;
    logic            tick_sec;
    logic            done;

    modport master (
        output load, load_hh, load_mm, load_ss, start, pause,
        input  count_hh, count_mm, count_ss, running, tick_sec, done
    );

    modport slave (
        input  load, load_hh, load_mm, load_ss, start, pause,
        output count_hh, count_mm, count_ss, running, tick_sec, done
    );

endinterface

// File: rtl/countdown_hms_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; holds its count while disabled.
module countdown_hms_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_hms.sv
// Loadable hh:mm:ss countdown timer with pause/resume and a done pulse at 00:00:00.
module countdown_hms
    import countdown_hms_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    countdown_hms_if.slave        bus
);

    state_e state_q, state_d;
    hms_t   cnt_q, cnt_d;
    logic   running_q, running_d;
    logic   tick_sec_q, tick_sec_d;
    logic   done_q, done_d;
    logic   tick;

    // Prescaler runs only in RUN, so it freezes across PAUSED and resumes where it stopped.
    countdown_hms_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .en   (state_q == RUN),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tick_sec_d = 1'b0;
        done_d     = 1'b0;

        if (bus.load) begin
            cnt_d   = sat_hms(bus.load_hh, bus.load_mm, bus.load_ss);
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.pause && bus.start && (cnt_q != '0)) state_d = RUN;
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        cnt_d      = dec_hms(cnt_q);
                        tick_sec_d = 1'b1;
                        if (cnt_d == '0) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (!bus.pause && bus.start) state_d = RUN;
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            running_q  <= 1'b0;
            tick_sec_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            running_q  <= running_d;
            tick_sec_q <= tick_sec_d;
            done_q     <= done_d;
        end
    end

    assign bus.count_hh = cnt_q.hh;
    assign bus.count_mm = cnt_q.mm;
    assign bus.count_ss = cnt_q.ss;
    assign bus.running  = running_q;
    assign bus.tick_sec = tick_sec_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_countdown_hms.sv
// Scoreboard bench for countdown_hms: stimulus queues expected outputs per clock edge,
// a negedge monitor pops and compares them.
module tb_countdown_hms;
    import countdown_hms_pkg::*;

    localparam int unsigned TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    countdown_hms_if bus();

    countdown_hms #(.TICK_DIV(TICK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [4:0]  hh;
        logic [5:0]  mm;
        logic [5:0]  ss;
        logic        run;
        logic        ts;
        logic        dn;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected outputs after posedge number c, kept sorted by cycle.
    task automatic expect_at(input int c, input string nm, input int hh, input int mm,
                             input int ss, input bit run, input bit ts, input bit dn);
        exp_t e;
        int   i;
        e.cyc = c; e.name = nm;
        e.hh = 5'(hh); e.mm = 6'(mm); e.ss = 6'(ss);
        e.run = run; e.ts = ts; e.dn = dn;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive_load(input int hh, input int mm, input int ss);
        bus.load    = 1'b1;
        bus.load_hh = 5'(hh);
        bus.load_mm = 6'(mm);
        bus.load_ss = 6'(ss);
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc < cyc) begin
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
                end else if (bus.count_hh !== e.hh || bus.count_mm !== e.mm || bus.count_ss !== e.ss ||
                             bus.running !== e.run || bus.tick_sec !== e.ts || bus.done !== e.dn) begin
                    $display("FAIL %s @%0d: got %0d:%0d:%0d run=%b tick=%b done=%b, want %0d:%0d:%0d run=%b tick=%b done=%b",
                             e.name, cyc, bus.count_hh, bus.count_mm, bus.count_ss, bus.running,
                             bus.tick_sec, bus.done, e.hh, e.mm, e.ss, e.run, e.ts, e.dn);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        int t, s, e0;
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.load_hh = '0; bus.load_mm = '0; bus.load_ss = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, "reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;

        // Full countdown from 00:01:02 to expiry
        e0 = cyc + 1; drive_load(0, 1, 2);
        expect_at(e0, "t1_load", 0, 1, 2, 0, 0, 0);
        @(negedge clk); bus.load = 1'b0; bus.start = 1'b1; t = cyc + 1;
        expect_at(t,       "t1_start",   0, 1, 2, 1, 0, 0);
        expect_at(t + 3,   "t1_pretick", 0, 1, 2, 1, 0, 0);
        expect_at(t + 4,   "t1_tick1",   0, 1, 1, 1, 1, 0);
        expect_at(t + 8,   "t1_tick2",   0, 1, 0, 1, 1, 0);
        expect_at(t + 12,  "t1_borrow",  0, 0, 59, 1, 1, 0);
        expect_at(t + 247, "t1_last1",   0, 0, 1, 1, 0, 0);
        expect_at(t + 248, "t1_done",    0, 0, 0, 0, 1, 1);
        expect_at(t + 249, "t1_after",   0, 0, 0, 0, 0, 0);
        expect_at(t + 250, "t1_exp_start", 0, 0, 0, 0, 0, 0);
        @(negedge clk); bus.start = 1'b0;
        wait_to(t + 249); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;

        // Hour borrow, then load mid-count with out-of-range preset
        @(negedge clk); e0 = cyc + 1; drive_load(1, 0, 0);
        expect_at(e0, "t2_load", 1, 0, 0, 0, 0, 0);
        @(negedge clk); bus.load = 1'b0; bus.start = 1'b1; t = cyc + 1;
        expect_at(t,     "t2_start",  1, 0, 0, 1, 0, 0);
        expect_at(t + 3, "t2_pre",    1, 0, 0, 1, 0, 0);
        expect_at(t + 4, "t2_hborrow", 0, 59, 59, 1, 1, 0);
        // 63 is the largest value the 6-bit preset ports carry
        expect_at(t + 7, "t6_load_run", 23, 59, 59, 0, 0, 0);
        expect_at(t + 8, "t6_idle",     23, 59, 59, 0, 0, 0);
        @(negedge clk); bus.start = 1'b0;
        wait_to(t + 6); drive_load(30, 63, 63);
        @(negedge clk); bus.load = 1'b0;
        @(negedge clk); bus.start = 1'b1; s = cyc + 1;
        expect_at(s,     "t6_start",  23, 59, 59, 1, 0, 0);
        expect_at(s + 3, "t6_clr",    23, 59, 59, 1, 0, 0);
        expect_at(s + 4, "t6_tick",   23, 59, 58, 1, 1, 0);
        @(negedge clk); bus.start = 1'b0;
        wait_to(s + 4);

        // Start with zero preset is ignored
        @(negedge clk); e0 = cyc + 1; drive_load(0, 0, 0);
        expect_at(e0, "t3_load0", 0, 0, 0, 0, 0, 0);
        @(negedge clk); bus.load = 1'b0; bus.start = 1'b1; t = cyc + 1;
        expect_at(t,     "t3_start0", 0, 0, 0, 0, 0, 0);
        expect_at(t + 5, "t3_hold0",  0, 0, 0, 0, 0, 0);
        @(negedge clk); bus.start = 1'b0;
        wait_to(t + 5);

        // Pause two cycles after start, hold, resume
        @(negedge clk); e0 = cyc + 1; drive_load(0, 0, 10);
        expect_at(e0, "t4_load", 0, 0, 10, 0, 0, 0);
        @(negedge clk); bus.load = 1'b0; bus.start = 1'b1; t = cyc + 1;
        expect_at(t,      "t4_start",  0, 0, 10, 1, 0, 0);
        expect_at(t + 1,  "t4_run",    0, 0, 10, 1, 0, 0);
        expect_at(t + 2,  "t4_paused", 0, 0, 10, 0, 0, 0);
        expect_at(t + 12, "t4_held",   0, 0, 10, 0, 0, 0);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.pause = 1'b1;
        @(negedge clk); bus.pause = 1'b0;
        wait_to(t + 12); bus.start = 1'b1; s = cyc + 1;
        expect_at(s,     "t4_resume", 0, 0, 10, 1, 0, 0);
        expect_at(s + 1, "t4_res1",   0, 0, 10, 1, 0, 0);
        expect_at(s + 2, "t4_res2",   0, 0, 9, 1, 1, 0);
        @(negedge clk); bus.start = 1'b0;
        wait_to(s + 2);

        // start and pause together in IDLE
        @(negedge clk); e0 = cyc + 1; drive_load(0, 0, 5);
        expect_at(e0, "t5_load", 0, 0, 5, 0, 0, 0);
        @(negedge clk); bus.load = 1'b0; bus.start = 1'b1; bus.pause = 1'b1; t = cyc + 1;
        expect_at(t,     "t5_both",  0, 0, 5, 0, 0, 0);
        expect_at(t + 5, "t5_still", 0, 0, 5, 0, 0, 0);
        @(negedge clk); bus.start = 1'b0; bus.pause = 1'b0;
        wait_to(t + 5);

        // rst on the tick that would expire 00:00:01
        @(negedge clk); e0 = cyc + 1; drive_load(0, 0, 2);
        expect_at(e0, "t7_load", 0, 0, 2, 0, 0, 0);
        @(negedge clk); bus.load = 1'b0; bus.start = 1'b1; t = cyc + 1;
        expect_at(t,     "t7_start", 0, 0, 2, 1, 0, 0);
        expect_at(t + 4, "t7_one",   0, 0, 1, 1, 1, 0);
        expect_at(t + 7, "t7_pre",   0, 0, 1, 1, 0, 0);
        expect_at(t + 8, "t7_rst",   0, 0, 0, 0, 0, 0);
        expect_at(t + 9, "t7_idle",  0, 0, 0, 0, 0, 0);
        @(negedge clk); bus.start = 1'b0;
        wait_to(t + 7); rst = 1'b1;
        @(negedge clk); rst = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        e0 = cyc + 1; drive_load(0, 0, 3);
        expect_at(e0, "t7_reload", 0, 0, 3, 0, 0, 0);
        @(negedge clk); bus.load = 1'b0; bus.start = 1'b1; s = cyc + 1;
        expect_at(s + 3, "t7_pre2",  0, 0, 3, 1, 0, 0);
        expect_at(s + 4, "t7_tick2", 0, 0, 2, 1, 1, 0);
        @(negedge clk); bus.start = 1'b0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never sampled, want 0", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
